// File: rtl/dcache_ctrl.sv
// dcache_ctrl: direct-mapped, write-back, write-allocate data cache controller.
// Hits complete in the same cycle as the request. A miss to a dirty victim
// spends one WRITEBACK cycle and then one REFILL cycle. A miss to a clean
// victim goes straight to REFILL. After either path the access hits in IDLE.
//
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   cpu_req/we/addr/be/wdata  CPU access; the request is held until cpu_ready
//   cpu_rdata, cpu_ready      load data (zero unless ready), access done
//   mem_wr_en/addr/wdata      one-cycle block writeback of the victim line
//   mem_read_addr, mem_rdata  refill address and combinational block return
//   miss_count                completed refills, wraps at 2^32
module dcache_ctrl #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int BLOCK_WIDTH   = 128,
  parameter int NUM_SETS      = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cpu_req,
  input  logic                     cpu_we,
  input  logic [ADDRESS_WIDTH-1:0] cpu_addr,
  input  logic [3:0]               cpu_be,
  input  logic [31:0]              cpu_wdata,
  output logic [31:0]              cpu_rdata,
  output logic                     cpu_ready,
  output logic                     mem_wr_en,
  output logic [ADDRESS_WIDTH-1:0] mem_addr,
  output logic [BLOCK_WIDTH-1:0]   mem_wdata,
  output logic [ADDRESS_WIDTH-1:0] mem_read_addr,
  input  logic [BLOCK_WIDTH-1:0]   mem_rdata,
  output logic [31:0]              miss_count
);
  localparam int IDX_W     = $clog2(NUM_SETS);
  localparam int TAG_W     = ADDRESS_WIDTH - 4 - IDX_W;
  localparam int NUM_LANES = 4;
  localparam int NUM_BYTES = BLOCK_WIDTH / 8;

  typedef enum logic [1:0] {IDLE, WRITEBACK, REFILL} state_t;

  state_t state_q, state_d;

  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] tag;
  logic [1:0]       wsel;

  assign idx  = cpu_addr[4+IDX_W-1:4];
  assign tag  = cpu_addr[ADDRESS_WIDTH-1:4+IDX_W];
  assign wsel = cpu_addr[3:2];

  // The low address bits select nothing: every access is word-sized.
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^cpu_addr[1:0];

  // Per-line state. Only valid/dirty are reset; tags and data are don't-care
  // until a refill sets valid.
  logic [NUM_SETS-1:0]    valid_q, dirty_q;
  logic [TAG_W-1:0]       tag_q  [NUM_SETS];
  logic [BLOCK_WIDTH-1:0] data_q [NUM_SETS];

  logic [BLOCK_WIDTH-1:0] line, merged;
  logic                   hit, st_en;

  assign line  = data_q[idx];
  assign hit   = (state_q == IDLE) && cpu_req && valid_q[idx] && (tag_q[idx] == tag);
  // A store with no byte strobes completes but leaves data and dirty untouched.
  assign st_en = hit && cpu_we && (|cpu_be);

  // Store merge: byte k of the line takes the CPU byte when the addressed
  // word contains it and its lane strobe is set.
  for (genvar k = 0; k < NUM_BYTES; k++) begin : g_byte
    logic byte_en;
    assign byte_en = (wsel == 2'(k / NUM_LANES)) && cpu_be[k % NUM_LANES];
    assign merged[8*k +: 8] = byte_en ? cpu_wdata[8*(k % NUM_LANES) +: 8]
                                      : line[8*k +: 8];
  end

  // State register plus the reset-controlled line bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      valid_q    <= '0;
      dirty_q    <= '0;
      miss_count <= '0;
    end else begin
      state_q <= state_d;
      if (st_en) dirty_q[idx] <= 1'b1;
      if (state_q == REFILL) begin
        valid_q[idx] <= 1'b1;
        dirty_q[idx] <= 1'b0;
        miss_count   <= miss_count + 32'd1;
      end
    end
  end

  // Data/tag arrays. An asynchronous reset forces state_q to IDLE, so a
  // transfer that is aborted by reset can never reach the REFILL write.
  always_ff @(posedge clk) begin
    if (st_en) begin
      data_q[idx] <= merged;
    end else if (state_q == REFILL) begin
      data_q[idx] <= mem_rdata;
      tag_q[idx]  <= tag;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (cpu_req && !hit)
                   state_d = (valid_q[idx] && dirty_q[idx]) ? WRITEBACK : REFILL;
      WRITEBACK: state_d = REFILL;
      REFILL:    state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // Outputs. The victim address and data are driven all the time. They only
  // matter while mem_wr_en is high.
  always_comb begin
    cpu_ready = hit;
    cpu_rdata = hit ? line[{wsel, 5'b0} +: 32] : 32'h0;
    mem_wr_en = (state_q == WRITEBACK);
    mem_addr  = {tag_q[idx], idx, 4'h0};
    mem_wdata = line;
  end

  assign mem_read_addr = {cpu_addr[ADDRESS_WIDTH-1:4], 4'h0};

endmodule

// File: tb/tb_dcache_ctrl.sv
// Table-driven bench for dcache_ctrl. A behavioural block memory returns
// {base+12, base+8, base+4, base} for any block, except the block at 0x00010000.
// Blocks that have been written back are returned as written.
module tb_dcache_ctrl;
  logic         clk = 1'b0;
  logic         rst_n;
  logic         cpu_req, cpu_we;
  logic [31:0]  cpu_addr, cpu_wdata, cpu_rdata;
  logic [3:0]   cpu_be;
  logic         cpu_ready, mem_wr_en;
  logic [31:0]  mem_addr, mem_read_addr, miss_count;
  logic [127:0] mem_wdata, mem_rdata;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  dcache_ctrl #(.ADDRESS_WIDTH(32), .BLOCK_WIDTH(128), .NUM_SETS(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_be(cpu_be),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
    .mem_wr_en(mem_wr_en), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_read_addr(mem_read_addr), .mem_rdata(mem_rdata), .miss_count(miss_count)
  );

  // Memory model
  logic [127:0] wb_mem [logic [31:0]];
  int           wb_gen = 0;

  function automatic logic [127:0] blk(input logic [31:0] a);
    logic [31:0] b;
    b = a & ~32'hF;
    if (wb_mem.exists(b)) return wb_mem[b];
    if (b == 32'h0001_0000)
      return {32'h55667788, 32'h99AABBCC, 32'hCAFEF00D, 32'h11223344};
    return {b + 32'd12, b + 32'd8, b + 32'd4, b};
  endfunction

  always @(mem_read_addr or wb_gen) mem_rdata = blk(mem_read_addr);

  always @(posedge clk) begin
    if (mem_wr_en) begin
      wb_mem[mem_addr] = mem_wdata;
      wb_gen++;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        chk_rd;
    logic [31:0] rdata;
    int          lat;      // cycles with cpu_ready low before completion
    int          wbs;      // writeback cycles seen during the access
    logic [31:0] wb_addr;
    logic [31:0] wb_w2;    // expected mem_wdata[95:64] on writeback
    logic [31:0] mc;       // miss_count after the access
  } vec_t;

  function automatic vec_t mk(input logic we, input logic [31:0] addr, input logic [3:0] be,
                              input logic [31:0] wdata, input logic chk_rd,
                              input logic [31:0] rdata, input int lat, input int wbs,
                              input logic [31:0] wb_addr, input logic [31:0] wb_w2,
                              input logic [31:0] mc);
    vec_t v;
    v.we = we; v.addr = addr; v.be = be; v.wdata = wdata; v.chk_rd = chk_rd;
    v.rdata = rdata; v.lat = lat; v.wbs = wbs; v.wb_addr = wb_addr; v.wb_w2 = wb_w2;
    v.mc = mc;
    return v;
  endfunction

  // Called at posedge+1. It returns at posedge+2 with cpu_req already dropped.
  task automatic access(input int n, input vec_t v);
    int lat = 0, wbs = 0;
    logic got = 1'b0, ra_ok = 1'b1;
    logic [31:0] rd = '0;
    cpu_req = 1'b1; cpu_we = v.we; cpu_addr = v.addr; cpu_be = v.be; cpu_wdata = v.wdata;
    for (int c = 0; c < 10 && !got; c++) begin
      @(negedge clk);
      if (mem_read_addr !== (v.addr & ~32'hF)) ra_ok = 1'b0;
      if (mem_wr_en) begin
        wbs++;
        chk($sformatf("v%0d wb_addr", n), mem_addr, v.wb_addr);
        chk($sformatf("v%0d wb_word2", n), mem_wdata[95:64], v.wb_w2);
      end
      if (cpu_ready) begin got = 1'b1; rd = cpu_rdata; end
      else lat++;
      @(posedge clk); #1;
    end
    cpu_req = 1'b0;
    chk($sformatf("v%0d completed", n), {31'b0, got}, 32'd1);
    chk($sformatf("v%0d latency", n), 32'(lat), 32'(v.lat));
    chk($sformatf("v%0d writebacks", n), 32'(wbs), 32'(v.wbs));
    chk($sformatf("v%0d read_addr", n), {31'b0, ra_ok}, 32'd1);
    if (v.chk_rd) chk($sformatf("v%0d rdata", n), rd, v.rdata);
    chk($sformatf("v%0d miss_count", n), miss_count, v.mc);
    #1;
    chk($sformatf("v%0d idle ready/rdata", n), {cpu_rdata[30:0], cpu_ready}, 32'd0);
  endtask

  vec_t vt[$];

  initial begin
    // ld 0x10000 refill; ld 0x10004 hit
    vt.push_back(mk(0, 32'h0001_0000, 4'h0, 0,            1, 32'h11223344, 2, 0, 0, 0, 1));
    vt.push_back(mk(0, 32'h0001_0004, 4'h0, 0,            1, 32'hCAFEF00D, 0, 0, 0, 0, 1));
    // store/load full word, byte-0 store into 0x55667788
    vt.push_back(mk(1, 32'h0001_0008, 4'hF, 32'hDEADBEEF, 0, 0,            0, 0, 0, 0, 1));
    vt.push_back(mk(0, 32'h0001_0008, 4'h0, 0,            1, 32'hDEADBEEF, 0, 0, 0, 0, 1));
    vt.push_back(mk(1, 32'h0001_000C, 4'h1, 32'h000000AA, 0, 0,            0, 0, 0, 0, 1));
    vt.push_back(mk(0, 32'h0001_000C, 4'h0, 0,            1, 32'h556677AA, 0, 0, 0, 0, 1));
    // be=0000 store leaves the word alone
    vt.push_back(mk(1, 32'h0001_0004, 4'h0, 32'hFFFFFFFF, 0, 0,            0, 0, 0, 0, 1));
    vt.push_back(mk(0, 32'h0001_0004, 4'h0, 0,            1, 32'hCAFEF00D, 0, 0, 0, 0, 1));
    // conflict miss on a dirty line: writeback, then refill
    vt.push_back(mk(0, 32'h0001_0200, 4'h0, 0,            1, 32'h00010200, 3, 1,
                    32'h0001_0000, 32'hDEADBEEF, 2));
    // be=0000 store to a clean line must not dirty it: the next eviction is clean
    vt.push_back(mk(1, 32'h0001_0200, 4'h0, 32'h12345678, 0, 0,            0, 0, 0, 0, 2));
    vt.push_back(mk(0, 32'h0001_0008, 4'h0, 0,            1, 32'hDEADBEEF, 2, 0, 0, 0, 3));
    vt.push_back(mk(0, 32'h0001_000C, 4'h0, 0,            1, 32'h556677AA, 0, 0, 0, 0, 3));
    // other sets: index 1 and index 31
    vt.push_back(mk(0, 32'h0000_0010, 4'h0, 0,            1, 32'h00000010, 2, 0, 0, 0, 4));
    vt.push_back(mk(0, 32'h0000_001C, 4'h0, 0,            1, 32'h0000001C, 0, 0, 0, 0, 4));
    vt.push_back(mk(0, 32'h0000_01F4, 4'h0, 0,            1, 32'h000001F4, 2, 0, 0, 0, 5));
    vt.push_back(mk(1, 32'h0000_01F8, 4'h6, 32'hAABBCCDD, 0, 0,            0, 0, 0, 0, 5));
    vt.push_back(mk(0, 32'h0000_01F8, 4'h0, 0,            1, 32'h00BBCCF8, 0, 0, 0, 0, 5));
    // dirty index 1 ahead of the reset-abort sequence
    vt.push_back(mk(1, 32'h0000_0010, 4'hF, 32'h12345678, 0, 0,            0, 0, 0, 0, 5));

    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_be = '0; cpu_wdata = '0;
    rst_n = 1'b0;
    #3;
    // Reset takes effect before any clock edge
    chk("reset cpu_ready", {31'b0, cpu_ready}, 32'd0);
    chk("reset mem_wr_en", {31'b0, mem_wr_en}, 32'd0);
    chk("reset miss_count", miss_count, 32'd0);
    @(negedge clk); rst_n = 1'b1;

    // Idle with no request
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("idle no-req", {cpu_rdata[29:0], cpu_ready, mem_wr_en}, 32'd0);
    end

    @(posedge clk); #1;
    for (int i = 0; i < vt.size(); i++) access(i, vt[i]);

    // Reset in the middle of a writeback: the transfer is aborted and dirty data is dropped
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0000_0210; cpu_be = '0;
    @(negedge clk);
    chk("abort idle-miss wr_en", {31'b0, mem_wr_en}, 32'd0);
    @(posedge clk); #1;
    chk("abort in WRITEBACK", {31'b0, mem_wr_en}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort wr_en falls", {31'b0, mem_wr_en}, 32'd0);
    chk("abort cpu_ready", {31'b0, cpu_ready}, 32'd0);
    chk("abort miss_count", miss_count, 32'd0);
    cpu_req = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    // Clean refill with no writeback, and memory still holds the original block
    access(100, mk(0, 32'h0000_0010, 4'h0, 0, 1, 32'h00000010, 2, 0, 0, 0, 1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/dcache_ctrl.md
DCACHE_CTRL -- requirements
Module: dcache_ctrl

Interface
REQ-001 The block SHALL have parameter ADDRESS_WIDTH, default 32, byte-address width.
REQ-002 The block SHALL have parameter BLOCK_WIDTH, default 128, line/memory block width in bits (16 bytes).
REQ-003 The block SHALL have parameter NUM_SETS, default 32, direct-mapped sets (power of two); index = addr[4+log2(NUM_SETS)-1:4]; tag = upper remaining bits; offset = addr[3:0].
REQ-004 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-005 The block SHALL have port clk, input, 1, rising-edge clock.
REQ-006 The block SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-007 The block SHALL have port cpu_req, input, 1, access request; held stable until cpu_ready.
REQ-008 The block SHALL have port cpu_we, input, 1, 1 = store, 0 = load.
REQ-009 The block SHALL have port cpu_addr, input, ADDRESS_WIDTH, byte address; addr[1:0] ignored.
REQ-010 The block SHALL have port cpu_be, input, 4, store byte strobes, bit i = byte lane i.
REQ-011 The block SHALL have port cpu_wdata, input, 32, store data.
REQ-012 The block SHALL have port cpu_rdata, output, 32, load data, valid when cpu_ready.
REQ-013 The block SHALL have port cpu_ready, output, 1, access completes this cycle.
REQ-014 The block SHALL have port mem_wr_en, output, 1, block write strobe to memory.
REQ-015 The block SHALL have port mem_addr, output, ADDRESS_WIDTH, 16-byte-aligned writeback address.
REQ-016 The block SHALL have port mem_wdata, output, BLOCK_WIDTH, writeback block, byte k at [8k+7:8k].
REQ-017 The block SHALL have port mem_read_addr, output, ADDRESS_WIDTH, refill address, 16-byte aligned.
REQ-018 The block SHALL have port mem_rdata, input, BLOCK_WIDTH, combinational block read of mem_read_addr.
REQ-019 The block SHALL have port miss_count, output, 32, number of completed refills.

Function
REQ-020 The block SHALL have FSM states IDLE, WRITEBACK and REFILL; per-line state SHALL be valid, dirty, tag and data.
REQ-021 In IDLE with cpu_req=1, a hit SHALL be valid & tag match and SHALL assert cpu_ready combinationally in the same cycle (zero-wait hit).
REQ-022 On a load hit, cpu_rdata SHALL equal word addr[3:2] of the line, where word w = bits [32w+31:32w].
REQ-023 On a store hit, the block SHALL update only the lanes enabled by cpu_be at the clock edge and set dirty=1; cpu_be=0000 SHALL complete without changing data or dirty.
REQ-024 On an IDLE miss with the victim valid & dirty, the FSM SHALL go to WRITEBACK; otherwise it SHALL go to REFILL; cpu_ready SHALL be 0 throughout.
REQ-025 WRITEBACK SHALL last 1 cycle with mem_wr_en=1, mem_addr={victim tag, index, 4'h0} and mem_wdata=victim line, and SHALL then go to REFILL.
REQ-026 REFILL SHALL last 1 cycle with mem_read_addr=cpu_addr & ~0xF; at the edge the block SHALL capture mem_rdata and set valid=1, dirty=0, tag=new tag, increment miss_count (wrapping at 2^32), and return to IDLE.
REQ-027 The access SHALL then hit in IDLE: miss latency SHALL be 2 cycles clean and 3 cycles dirty, counted from request to cpu_ready.
REQ-028 mem_wr_en SHALL be 0 in every state except WRITEBACK; mem_read_addr SHALL equal cpu_addr & ~0xF in all states.
REQ-029 cpu_req=0 in IDLE SHALL produce no state change, cpu_ready=0 and no memory write.
REQ-030 cpu_rdata SHALL be 0 when cpu_ready=0.

Reset
REQ-031 While rst_n=0, immediately and without waiting for clk, state SHALL be IDLE, all valid and dirty bits SHALL be 0, miss_count SHALL be 0, mem_wr_en SHALL be 0 and cpu_ready SHALL be 0; line data and tags SHALL be don't-care.
REQ-032 Reset asserted during WRITEBACK or REFILL SHALL abort the transfer; no partial line update SHALL occur, and dirty data SHALL be discarded.

Verification
REQ-033 Reset, load 0x00010000 (memory word 0x11223344) -> 1 cycle REFILL with mem_read_addr=0x00010000, then cpu_ready=1 and cpu_rdata=0x11223344; miss_count=1.
REQ-034 Next, load 0x00010004 -> cpu_ready=1 in the same cycle, mem_wr_en=0, miss_count unchanged.
REQ-035 Store 0xDEADBEEF with be=1111 to 0x00010008, then load 0x00010008 -> both hit, read returns 0xDEADBEEF; store 0x000000AA with be=0001 to 0x0001000C (prior 0x55667788) -> reads 0x556677AA.
REQ-036 Then load 0x00010200 (same index 0, different tag) -> WRITEBACK cycle with mem_wr_en=1, mem_addr=0x00010000, mem_wdata[95:64]=0xDEADBEEF, then REFILL at 0x00010200, cpu_ready on cycle 3; miss_count=2.
REQ-037 Drive rst_n=0 mid-WRITEBACK -> mem_wr_en falls before the next edge; after release, load 0x00010000 misses (refill, no writeback).
